enc_drain8to3: RTL
==================

Name: enc_drain8to3

Overview:
- Sequential inverse of the 2-to-4 / 3-to-8 decoder chain: accepts an N-bit vector (one or more lines set) and emits the binary index of every set bit, one index per handshake, lowest index first.
- Sits between request/flag collectors and downstream logic that wants encoded indices, e.g. re-encoding decoder minterm lines such as M[0:7] back into 3-bit codes.
- Valid/ready on both sides; holds one vector at a time.

Parameters:
- N, 8, width of input vector; power of two, 2..64
- W, 3, index width; must equal log2(N)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_vec is presented
- in_ready  output  1  block can accept a vector
- in_vec  input  N  lines to encode; bit i set means index i pending
- out_valid  output  1  out_idx is valid
- out_ready  input  1  downstream accepts out_idx
- out_idx  output  W  encoded index of current pending bit
- out_last  output  1  current index is the last one of this vector
- zero_pulse  output  1  one-cycle pulse: an all-zero vector was accepted
- busy  output  1  vector held, not yet drained

Behaviour:
- Reset (async assert, sync-safe deassert on next clk): state=IDLE, pend=0. Outputs: in_ready=1, out_valid=0, out_idx=0, out_last=0, zero_pulse=0, busy=0.
- States IDLE, EMIT. One internal register pend[N-1:0].
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready with in_vec!=0: pend<=in_vec, go EMIT.
  - On in_valid&in_ready with in_vec==0: stay IDLE, zero_pulse=1 next cycle only.
- EMIT:
  - in_ready=0, busy=1, out_valid=1.
  - out_idx = index of lowest set bit of pend.
  - out_last=1 iff pend has exactly one bit set.
  - out_idx and out_last are decoded from the registered pend and held stable while out_valid&!out_ready.
  - On out_valid&out_ready: clear bit out_idx in pend. If out_last, go IDLE (in_ready=1 next cycle); otherwise stay EMIT with the next index next cycle.
- Latency:
  - Vector accepted at edge k: first out_valid at cycle k+1.
  - Throughput one index per cycle while out_ready=1.
  - Vector with P set bits occupies P cycles of EMIT minimum.
  - Next vector accepted no earlier than the cycle after the last handshake; no overlap.
- out_idx in IDLE holds 0; out_last 0.
- in_vec sampled only at accept; changes afterward ignored.
- Reset asserted mid-EMIT: pend cleared immediately; pending indices discarded; no further out_valid.
- out_ready asserted in IDLE: no effect.
- All-ones vector: N indices 0..N-1, out_last on index N-1.

Optional Feature:
- Macro ENC_MSB_FIRST_EN.
- Defined: priority reversed. out_idx is the highest set bit of pend; drain order N-1 down to 0. out_last rule unchanged.
- Undefined: lowest-index-first as above.
- No port or timing change either way.

Test Plan:
- Reset: rst_n=0 mid-cycle -> outputs immediately in_ready=1, out_valid=0, out_idx=0, busy=0; after release idle.
- Single bit: in_vec=8'b0010_0000, out_ready=1 -> next cycle out_valid=1, out_idx=5, out_last=1; following cycle in_ready=1, busy=0.
- Multi-bit with stall: in_vec=8'b1000_1001, out_ready held 0 for 3 cycles then 1 -> out_idx=0 stable during stall, then 0,3,7 on consecutive cycles, out_last only with 7. With ENC_MSB_FIRST_EN the order is 7,3,0.
- Zero vector: in_vec=8'h00 accepted -> zero_pulse=1 for exactly one cycle, out_valid never asserts, in_ready stays 1.
- Back-to-back: in_vec=8'hFF then 8'h02 held valid -> indices 0..7 (last on 7), second vector accepted the cycle after, out_idx=1 with out_last=1; in_vec changes during drain are ignored.
- Reset mid-drain: 8'hF0, drop rst_n after idx 4 handshake -> out_valid=0 at once; after release no residual indices.

Source files
------------

// File: rtl/enc_drain8to3.sv
// Sequential priority encoder: holds one N-bit vector and emits the index of each set bit, one per handshake.
// Build option ENC_MSB_FIRST_EN drains the highest set bit first instead of the lowest.
module enc_drain8to3 #(
  parameter int N = 8,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         zero_pulse,
  output logic         busy
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   pend_q, pend_d;
  logic           zero_pulse_q, zero_pulse_d;
  logic [W-1:0]   pick_idx;
  logic           pick_single;
  logic [N-1:0]   pick_mask;

  // Later loop iterations win, so the scan direction sets the drain priority.
  always_comb begin
    pick_idx = '0;
`ifdef ENC_MSB_FIRST_EN
    for (int i = 0; i < N; i++) begin
      if (pend_q[i]) pick_idx = i[W-1:0];
    end
`else
    for (int i = N - 1; i >= 0; i--) begin
      if (pend_q[i]) pick_idx = i[W-1:0];
    end
`endif
  end

  always_comb begin
    pick_single = (pend_q != '0) && ((pend_q & (pend_q - N'(1))) == '0);
    pick_mask   = N'(1) << pick_idx;
  end

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    zero_pulse_d = 1'b0;
    if (state_q == IDLE) begin
      if (in_valid) begin
        if (in_vec != '0) begin
          pend_d  = in_vec;
          state_d = EMIT;
        end else begin
          zero_pulse_d = 1'b1;
        end
      end
    end else begin
      if (out_ready) begin
        pend_d = pend_q & ~pick_mask;
        if (pick_single) state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      zero_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      zero_pulse_q <= zero_pulse_d;
    end
  end

  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == EMIT);
    busy       = (state_q == EMIT);
    out_idx    = (state_q == EMIT) ? pick_idx : '0;
    out_last   = (state_q == EMIT) && pick_single;
    zero_pulse = zero_pulse_q;
  end

endmodule
